// File: rtl/conbus_pkg.sv
// Shared definitions for the conbus scheduler: FSM encoding, default sizing
// and diagnostic counter widths.
package conbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam int DEF_N_MASTERS = 6;
  localparam int DEF_TIMEOUT   = 255;
  localparam int DEF_TO_W      = 8;
  localparam int CNT_W         = 16;
  localparam int LAST_W        = 3;

endpackage

// File: rtl/conbus_sched_if.sv
// Scheduler-facing bundle of the interconnect: master requests, the muxed bus
// strobe/ack, and the grant/error/diagnostic outputs.
interface conbus_sched_if #(
  parameter int N_MASTERS = conbus_pkg::DEF_N_MASTERS
);
  import conbus_pkg::*;

  // Handshake: req[i] is master i's cyc and stays high for its whole cycle;
  // gnt is one-hot on the owner; a beat completes on a clock edge where
  // bus_stb && bus_ack are both high; m_err is a one-cycle abort of the owner.
  logic [N_MASTERS-1:0] req;
  logic                 bus_stb;
  logic                 bus_ack;
  logic                 cnt_clr;
  logic [N_MASTERS-1:0] gnt;
  logic [N_MASTERS-1:0] m_err;
  logic [CNT_W-1:0]     to_count;
  logic [LAST_W-1:0]    to_last;
  state_t               state;

  modport slave (
    input  req, bus_stb, bus_ack, cnt_clr,
    output gnt, m_err, to_count, to_last, state
  );

  modport master (
    output req, bus_stb, bus_ack, cnt_clr,
    input  gnt, m_err, to_count, to_last, state
  );

endinterface

// File: rtl/conbus_rr_pick.sv
// Combinational rotate-priority picker: first set req bit scanning upward
// from last+1, wrapping at N_MASTERS-1.
module conbus_rr_pick #(
  parameter int N_MASTERS = 6,
  parameter int IDX_W     = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic                 any,
  output logic [IDX_W-1:0]     pick
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] j;
    any   = |req;
    pick  = last;
    found = 1'b0;
    j     = '0;
    // i runs to N_MASTERS so last itself is considered after everyone else
    for (int i = 1; i <= N_MASTERS; i++) begin
      j = IDX_W'((int'(last) + i) % N_MASTERS);
      if (!found && req[j]) begin
        pick  = j;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/conbus_sched.sv
// Round-robin Wishbone bus scheduler with a per-transfer watchdog that aborts
// stalled beats and keeps a saturating timeout count.
module conbus_sched
  import conbus_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int TO_W      = DEF_TO_W
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  conbus_sched_if.slave  bus
);

  localparam int IDX_W = $clog2(N_MASTERS);

  state_t               state_q, state_n;
  logic [IDX_W-1:0]     owner_q, owner_n;
  logic [IDX_W-1:0]     last_q, last_n;
  logic [TO_W-1:0]      wdt_q, wdt_n;
  logic [N_MASTERS-1:0] gnt_q, gnt_n;
  logic [N_MASTERS-1:0] m_err_q, m_err_n;
  logic [CNT_W-1:0]     to_count_q, to_count_n;
  logic [LAST_W-1:0]    to_last_q, to_last_n;
  logic                 abort_enter;
  logic                 any;
  logic [IDX_W-1:0]     pick;

  // last always equals the current owner while granted, so one picker
  // serves both the IDLE start and the direct handover.
  conbus_rr_pick #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req  (bus.req),
    .last (last_q),
    .any  (any),
    .pick (pick)
  );

  always_comb begin
    state_n     = state_q;
    owner_n     = owner_q;
    last_n      = last_q;
    wdt_n       = '0;
    abort_enter = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_n = GRANT;
          owner_n = pick;
          last_n  = pick;
        end
      end
      GRANT: begin
        // Release is checked first so it beats a coincident expiry.
        if (!bus.req[owner_q]) begin
          if (any) begin
            owner_n = pick;
            last_n  = pick;
          end else begin
            state_n = IDLE;
          end
        end else if (bus.bus_stb && !bus.bus_ack) begin
          if (wdt_q == TO_W'(TIMEOUT - 1)) begin
            state_n     = ABORT;
            abort_enter = 1'b1;
          end else begin
            wdt_n = wdt_q + 1'b1;
          end
        end
      end
      ABORT:   state_n = GRANT;
      default: state_n = IDLE;
    endcase

    gnt_n   = '0;
    m_err_n = '0;
    if (state_n != IDLE) gnt_n[owner_n] = 1'b1;
    if (state_n == ABORT) m_err_n[owner_n] = 1'b1;

    to_count_n = to_count_q;
    to_last_n  = to_last_q;
    if (abort_enter) to_last_n = LAST_W'(owner_q);
    if (bus.cnt_clr) to_count_n = '0;
    else if (abort_enter && (to_count_q != {CNT_W{1'b1}})) to_count_n = to_count_q + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= IDX_W'(N_MASTERS - 1);
      wdt_q      <= '0;
      gnt_q      <= '0;
      m_err_q    <= '0;
      to_count_q <= '0;
      to_last_q  <= '0;
    end else begin
      state_q    <= state_n;
      owner_q    <= owner_n;
      last_q     <= last_n;
      wdt_q      <= wdt_n;
      gnt_q      <= gnt_n;
      m_err_q    <= m_err_n;
      to_count_q <= to_count_n;
      to_last_q  <= to_last_n;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.m_err    = m_err_q;
  assign bus.to_count = to_count_q;
  assign bus.to_last  = to_last_q;
  assign bus.state    = state_q;

endmodule
